// File: rtl/mips_pkg.sv
// Shared constants and write-request record for the register-file write path.
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic              kill;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small in-order buffer for MDU register writes, with per-entry WAW kill and
// per-entry destination compare for the hazard unit's busy flags.
module regfile_wr_fifo
  import mips_pkg::*;
#(
  parameter int  DATA_W = mips_pkg::DATA_W,
  parameter int  ADDR_W = mips_pkg::ADDR_W,
  parameter int  DEPTH  = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_reg_i,
  input  logic [ADDR_W-1:0] cmp_reg1_i,
  input  logic [ADDR_W-1:0] cmp_reg2_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_live_o,
  output logic [ADDR_W-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [DEPTH-1:0]  match1_o,
  output logic [DEPTH-1:0]  match2_o
);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign head_live_o = vld_q[rd_ptr_q] & ~kill_q[rd_ptr_q];
  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_comb begin
    vld_d    = vld_q;
    kill_d   = kill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // A kill only marks entries already stored; a killed entry still drains in order.
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (reg_q[i] == kill_reg_i)) kill_d[i] = 1'b1;
      end
    end
    if (pop_ok) begin
      vld_d[rd_ptr_q]  = 1'b0;
      kill_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      vld_d[wr_ptr_q]  = 1'b1;
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    match1_o = '0;
    match2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1_o[i] = vld_q[i] & ~kill_q[i] & (reg_q[i] == cmp_reg1_i);
      match2_o[i] = vld_q[i] & ~kill_q[i] & (reg_q[i] == cmp_reg2_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      kill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      kill_q   <= kill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: it is only observed through the valid bits.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      reg_q[wr_ptr_q]  <= push_reg_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between WB (priority) and a buffered
// MDU stream, with a starvation stall and hazard busy flags for pending MDU writes.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W       = mips_pkg::DATA_W,
  parameter int ADDR_W       = mips_pkg::ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WbWrite,
  input  logic [ADDR_W-1:0] WbReg,
  input  logic [DATA_W-1:0] WbData,
  input  logic              MduValid,
  output logic              MduReady,
  input  logic [ADDR_W-1:0] MduReg,
  input  logic [DATA_W-1:0] MduData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              Busy1,
  output logic              Busy2,
  output logic              StallPipe,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite_ctrl
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);

  // Handshake: an MDU result transfers on a cycle where MduValid and MduReady
  // are both high; while Valid=1 and Ready=0 the MDU holds MduReg/MduData.

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_live;
  logic [ADDR_W-1:0]     head_reg;
  logic [DATA_W-1:0]     head_data;
  logic [FIFO_DEPTH-1:0] match1;
  logic [FIFO_DEPTH-1:0] match2;

  logic                  wb_grant;
  logic                  fifo_grant;
  logic                  mdu_push;
  logic                  wb_kill;

  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [SCNT_W-1:0]     starve_q, starve_d;
  logic                  stall_q, stall_d;

  assign MduReady   = ~fifo_full;
  assign wb_grant   = WbWrite & ~stall_q;
  assign fifo_grant = ~wb_grant & ~fifo_empty;
  // Writes to r0 are dropped at the door rather than occupying a slot.
  assign mdu_push   = MduValid & MduReady & (MduReg != ZERO_REG);
  assign wb_kill    = wb_grant & (WbReg != ZERO_REG);

  regfile_wr_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (mdu_push),
    .push_reg_i  (MduReg),
    .push_data_i (MduData),
    .pop_i       (fifo_grant),
    .kill_i      (wb_kill),
    .kill_reg_i  (WbReg),
    .cmp_reg1_i  (ReadReg1),
    .cmp_reg2_i  (ReadReg2),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_live_o (head_live),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .match1_o    (match1),
    .match2_o    (match2)
  );

  assign Busy1 = (ReadReg1 != ZERO_REG) & (|match1);
  assign Busy2 = (ReadReg2 != ZERO_REG) & (|match2);

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (wb_grant) begin
      we_d    = (WbReg != ZERO_REG);
      wreg_d  = WbReg;
      wdata_d = WbData;
    end else if (fifo_grant) begin
      we_d    = head_live & (head_reg != ZERO_REG);
      wreg_d  = head_reg;
      wdata_d = head_data;
    end
  end

  // Starvation: count WB wins over a waiting FIFO; the stall lasts one cycle
  // because the forced pop clears the count on the same edge.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_grant) begin
      starve_d = '0;
    end else if (wb_grant) begin
      starve_d = starve_q + SCNT_W'(1);
    end
    stall_d = (starve_d == SCNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign RegWrite_ctrl = we_q;
  assign WriteReg      = wreg_q;
  assign WriteData     = wdata_q;
  assign StallPipe     = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, hand-written starvation
// and reset sequences, then random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
  import mips_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int NRAND = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              WbWrite = 1'b0;
  logic [ADDR_W-1:0] WbReg = '0;
  logic [DATA_W-1:0] WbData = '0;
  logic              MduValid = 1'b0;
  logic              MduReady;
  logic [ADDR_W-1:0] MduReg = '0;
  logic [DATA_W-1:0] MduData = '0;
  logic [ADDR_W-1:0] ReadReg1 = '0;
  logic [ADDR_W-1:0] ReadReg2 = '0;
  logic              Busy1, Busy2, StallPipe, RegWrite_ctrl;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .MduValid(MduValid), .MduReady(MduReady), .MduReg(MduReg), .MduData(MduData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .Busy1(Busy1), .Busy2(Busy2),
    .StallPipe(StallPipe), .WriteReg(WriteReg), .WriteData(WriteData),
    .RegWrite_ctrl(RegWrite_ctrl)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              wb;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic              mv;
    logic [ADDR_W-1:0] mreg;
    logic [DATA_W-1:0] mdata;
    logic [ADDR_W-1:0] rr1, rr2;
    logic              x_ready, x_busy1, x_busy2, x_we, x_chk_wd;
    logic [ADDR_W-1:0] x_wreg;
    logic [DATA_W-1:0] x_wdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(input int wb, input int wreg, input int wdata, input int mv,
                              input int mreg, input int mdata, input int rr1, input int rr2,
                              input int rdy, input int b1, input int b2, input int we,
                              input int cwd, input int xreg, input int xdata);
    vec_t v;
    v.wb = 1'(wb);  v.wreg = ADDR_W'(wreg);  v.wdata = DATA_W'(wdata);
    v.mv = 1'(mv);  v.mreg = ADDR_W'(mreg);  v.mdata = DATA_W'(mdata);
    v.rr1 = ADDR_W'(rr1);  v.rr2 = ADDR_W'(rr2);
    v.x_ready = 1'(rdy);  v.x_busy1 = 1'(b1);  v.x_busy2 = 1'(b2);
    v.x_we = 1'(we);  v.x_chk_wd = 1'(cwd);
    v.x_wreg = ADDR_W'(xreg);  v.x_wdata = DATA_W'(xdata);
    return v;
  endfunction

  // ---------------- reference model ----------------
  wr_req_t           mq[$];
  int                m_starve;
  bit                m_stall;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_wreg;
  logic [DATA_W-1:0] exp_wdata;
  logic [DATA_W-1:0] m_rf [32];
  logic [DATA_W-1:0] d_rf [32];

  function automatic bit m_busy(input logic [ADDR_W-1:0] r);
    if (r == '0) return 1'b0;
    foreach (mq[i]) if (!mq[i].kill && mq[i].waddr == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit wb_g, ne, rdy, popped;
    wr_req_t h, n;
    wb_g = WbWrite && !m_stall;
    ne = (mq.size() > 0);
    rdy = (mq.size() < DEPTH);
    popped = 1'b0;
    exp_we = 1'b0;
    if (wb_g) begin
      exp_we = (WbReg != '0);
      exp_wreg = WbReg;
      exp_wdata = WbData;
      if (WbReg != '0) foreach (mq[i]) if (mq[i].waddr == WbReg) mq[i].kill = 1'b1;
    end else if (ne) begin
      h = mq.pop_front();
      exp_we = !h.kill;
      exp_wreg = h.waddr;
      exp_wdata = h.data;
      popped = 1'b1;
    end
    if (!ne || popped) m_starve = 0;
    else if (wb_g) m_starve++;
    m_stall = (m_starve == LIMIT);
    if (MduValid && rdy && MduReg != '0) begin
      n.valid = 1'b1; n.kill = 1'b0; n.waddr = MduReg; n.data = MduData;
      mq.push_back(n);
    end
  endtask

  task automatic set_idle();
    WbWrite = 1'b0; WbReg = '0; WbData = '0;
    MduValid = 1'b0; MduReg = '0; MduData = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit mdu_hold;

    vecs[0]  = mk(1, 1, 'hABCD, 0, 0, 0,      0, 0, 1, 0, 0, 1, 1, 1, 'hABCD);
    vecs[1]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0, 0, 1, 1, 'hABCD);
    vecs[2]  = mk(0, 0, 0,      1, 2, 'h1234, 2, 3, 1, 0, 0, 0, 1, 1, 'hABCD);
    vecs[3]  = mk(0, 0, 0,      1, 3, 'h5678, 2, 3, 1, 1, 0, 1, 1, 2, 'h1234);
    vecs[4]  = mk(0, 0, 0,      0, 0, 0,      2, 3, 1, 0, 1, 1, 1, 3, 'h5678);
    vecs[5]  = mk(0, 0, 0,      0, 0, 0,      2, 3, 1, 0, 0, 0, 1, 3, 'h5678);
    vecs[6]  = mk(0, 0, 0,      1, 6, 'h1111, 6, 0, 1, 0, 0, 0, 1, 3, 'h5678);
    vecs[7]  = mk(1, 6, 'h2222, 0, 0, 0,      6, 0, 1, 1, 0, 1, 1, 6, 'h2222);
    vecs[8]  = mk(0, 0, 0,      0, 0, 0,      6, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 'hDEAD, 1, 0, 'hBEEF, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 9, 'h9999, 1, 0, 'hBEEF, 0, 0, 1, 0, 0, 1, 1, 9, 'h9999);
    vecs[11] = mk(1, 9, 'hAAAA, 0, 0, 0,      0, 0, 1, 0, 0, 1, 1, 9, 'hAAAA);
    vecs[12] = mk(0, 0, 0,      0, 0, 0,      0, 0, 1, 0, 0, 0, 1, 9, 'hAAAA);

    // clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst RegWrite", 32'(RegWrite_ctrl), 0);
    chk("rst WriteReg", 32'(WriteReg), 0);
    chk("rst WriteData", WriteData, 0);
    chk("rst MduReady", 32'(MduReady), 1);
    chk("rst StallPipe", 32'(StallPipe), 0);

    // table-driven directed cases
    for (int i = 0; i < NV; i++) begin
      WbWrite = vecs[i].wb;  WbReg = vecs[i].wreg;  WbData = vecs[i].wdata;
      MduValid = vecs[i].mv; MduReg = vecs[i].mreg; MduData = vecs[i].mdata;
      ReadReg1 = vecs[i].rr1; ReadReg2 = vecs[i].rr2;
      @(negedge clk);
      chk($sformatf("vec%0d MduReady", i), 32'(MduReady), 32'(vecs[i].x_ready));
      chk($sformatf("vec%0d Busy1", i), 32'(Busy1), 32'(vecs[i].x_busy1));
      chk($sformatf("vec%0d Busy2", i), 32'(Busy2), 32'(vecs[i].x_busy2));
      chk($sformatf("vec%0d StallPipe", i), 32'(StallPipe), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d RegWrite", i), 32'(RegWrite_ctrl), 32'(vecs[i].x_we));
      if (vecs[i].x_chk_wd) begin
        chk($sformatf("vec%0d WriteReg", i), 32'(WriteReg), 32'(vecs[i].x_wreg));
        chk($sformatf("vec%0d WriteData", i), WriteData, vecs[i].x_wdata);
      end
    end

    // starvation: FIFO holds 4,5 while WB writes r10 every cycle
    for (int c = 0; c < 12; c++) begin
      WbWrite = (c <= 10);
      WbReg = 5'd10;
      WbData = 32'h100 + 32'(c);
      MduValid = (c < 2);
      MduReg = (c == 0) ? 5'd4 : 5'd5;
      MduData = (c == 0) ? 32'h44 : 32'h55;
      ReadReg1 = 5'd5;
      ReadReg2 = 5'd4;
      @(negedge clk);
      chk($sformatf("starve%0d MduReady", c), 32'(MduReady), 32'(!(c >= 2 && c <= 5)));
      chk($sformatf("starve%0d Busy1", c), 32'(Busy1), 32'(c >= 2 && c <= 10));
      chk($sformatf("starve%0d Busy2", c), 32'(Busy2), 32'(c >= 1 && c <= 5));
      chk($sformatf("starve%0d StallPipe", c), 32'(StallPipe), 32'(c == 5 || c == 10));
      @(posedge clk); #1;
      if (c == 11) begin
        chk($sformatf("starve%0d RegWrite", c), 32'(RegWrite_ctrl), 0);
      end else begin
        chk($sformatf("starve%0d RegWrite", c), 32'(RegWrite_ctrl), 1);
        chk($sformatf("starve%0d WriteReg", c), 32'(WriteReg),
            (c == 5) ? 32'd4 : (c == 10) ? 32'd5 : 32'd10);
        chk($sformatf("starve%0d WriteData", c), WriteData,
            (c == 5) ? 32'h44 : (c == 10) ? 32'h55 : 32'h100 + 32'(c));
      end
    end

    // asynchronous reset with two entries queued
    WbWrite = 1'b1; WbReg = 5'd11; WbData = 32'hB0B;
    MduValid = 1'b1; MduReg = 5'd12; MduData = 32'hC0C;
    @(posedge clk); #1;
    MduReg = 5'd13; MduData = 32'hD0D;
    @(posedge clk); #1;
    chk("prerst RegWrite", 32'(RegWrite_ctrl), 1);
    chk("prerst WriteReg", 32'(WriteReg), 11);
    set_idle();
    ReadReg1 = 5'd12; ReadReg2 = 5'd13;
    #2;
    chk("prerst Busy1", 32'(Busy1), 1);
    chk("prerst MduReady", 32'(MduReady), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst RegWrite", 32'(RegWrite_ctrl), 0);
    chk("midrst WriteReg", 32'(WriteReg), 0);
    chk("midrst WriteData", WriteData, 0);
    chk("midrst MduReady", 32'(MduReady), 1);
    chk("midrst StallPipe", 32'(StallPipe), 0);
    chk("midrst Busy1", 32'(Busy1), 0);
    chk("midrst Busy2", 32'(Busy2), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst%0d RegWrite", c), 32'(RegWrite_ctrl), 0);
      chk($sformatf("postrst%0d MduReady", c), 32'(MduReady), 1);
      chk($sformatf("postrst%0d Busy", c), 32'(Busy1 | Busy2), 0);
    end

    // randomized traffic against the queue model
    mq.delete();
    m_starve = 0;
    m_stall = 1'b0;
    for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
    mdu_hold = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      WbWrite = ($urandom_range(0, 99) < 55);
      WbReg = ADDR_W'($urandom_range(0, 7));
      WbData = $urandom;
      if (!mdu_hold) begin
        MduValid = ($urandom_range(0, 99) < 50);
        MduReg = ADDR_W'($urandom_range(0, 7));
        MduData = $urandom;
      end
      ReadReg1 = ADDR_W'($urandom_range(0, 7));
      ReadReg2 = ADDR_W'($urandom_range(0, 7));
      @(negedge clk);
      chk("rand MduReady", 32'(MduReady), 32'(mq.size() < DEPTH));
      chk("rand Busy1", 32'(Busy1), 32'(m_busy(ReadReg1)));
      chk("rand Busy2", 32'(Busy2), 32'(m_busy(ReadReg2)));
      chk("rand StallPipe", 32'(StallPipe), 32'(m_stall));
      mdu_hold = MduValid && !(mq.size() < DEPTH);
      @(posedge clk);
      model_step();
      #1;
      chk("rand RegWrite", 32'(RegWrite_ctrl), 32'(exp_we));
      if (exp_we) begin
        chk("rand WriteReg", 32'(WriteReg), 32'(exp_wreg));
        chk("rand WriteData", WriteData, exp_wdata);
        m_rf[exp_wreg] = exp_wdata;
      end
      if (RegWrite_ctrl) d_rf[WriteReg] = WriteData;
    end
    for (int r = 1; r < 32; r++) chk($sformatf("rf r%0d", r), d_rf[r], m_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the pipelined register file between two producers:
  - the WB stage, which has fixed priority and is never back-pressured except by the starvation stall;
  - a multi-cycle unit (MDU / late-load path), which uses a valid/ready handshake into a 2-entry FIFO.
- Sits between WB/MDU and the register file, and drives WriteReg, WriteData and RegWrite_ctrl.
- Also exports per-read-port busy flags that the hazard unit uses to stall on pending MDU writes.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 2, MDU buffer entries (power of two, at least 2)
- STARVE_LIMIT, 4, consecutive WB-preempted cycles with a non-empty FIFO before StallPipe fires

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- WbWrite  in  1  WB stage write request
- WbReg  in  ADDR_W  WB destination register
- WbData  in  DATA_W  WB write data
- MduValid  in  1  MDU result valid
- MduReady  out  1  FIFO can accept (high when not full)
- MduReg  in  ADDR_W  MDU destination register
- MduData  in  DATA_W  MDU result
- ReadReg1  in  ADDR_W  hazard query, read port 1
- ReadReg2  in  ADDR_W  hazard query, read port 2
- Busy1  out  1  a pending MDU write targets ReadReg1
- Busy2  out  1  a pending MDU write targets ReadReg2
- StallPipe  out  1  WB must hold its request this cycle
- WriteReg  out  ADDR_W  to register file
- WriteData  out  DATA_W  to register file
- RegWrite_ctrl  out  1  to register file

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, rst_n low):
  - WriteReg=0, WriteData=0, RegWrite_ctrl=0;
  - FIFO empty, MduReady=1;
  - starvation counter=0, StallPipe=0.
- Reset asserted mid-operation discards all queued entries immediately. No write is issued during reset.
- Outputs are registered. A grant in cycle N drives the port in cycle N+1, and the register file commits at the end of N+1.
- Per-cycle grant:
  - If WbWrite=1 and StallPipe=0 → WB granted.
  - Else if FIFO non-empty → FIFO head granted and popped.
  - Else RegWrite_ctrl=0 next cycle; WriteReg/WriteData hold their previous values.
- Register 0: a granted write with WbReg=0 or head reg=0 issues RegWrite_ctrl=0. MDU pushes with MduReg=0 are accepted and discarded, never enqueued.
- MDU handshake:
  - A push happens when MduValid & MduReady.
  - MduReady = !full. Full is evaluated on the registered count, so a pop and a push in the same cycle while full do not allow acceptance.
  - The MDU holds MduReg and MduData stable while Valid=1 and Ready=0.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, pointers advance.
- Push into an empty FIFO is not granted in the same cycle (no bypass). Minimum MDU latency is 2 cycles from push to port.
- WAW kill: when WB is granted with WbReg≠0, every valid FIFO entry whose reg equals WbReg is invalidated, so the newer WB value is not overwritten. Killed entries are still popped in order but issue RegWrite_ctrl=0.
- Busy1 is combinational: Busy1 = ReadReg1≠0 & (any valid, un-killed FIFO entry with reg=ReadReg1). Busy2 is the same for ReadReg2. The output register stage is excluded, because the register file handles write-then-read.
- Starvation:
  - The counter increments each cycle that WB is granted while the FIFO is non-empty, and clears when the FIFO pops or empties.
  - When the counter reaches STARVE_LIMIT, StallPipe=1 for exactly one cycle (registered). The FIFO head is granted that cycle and the counter clears.
- Pointers wrap modulo FIFO_DEPTH. The count width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W and DATA_W constants;
  - a wr_req_t struct {valid, kill, reg, data};
  - the ZERO_REG constant.
- One natural sub-module: regfile_wr_fifo. It holds the FIFO storage, pointers and count, and provides per-entry kill-by-match and per-entry reg compare outputs for Busy generation. The arbiter, starvation counter and output registers stay in the top.

Test Plan:
- Reset then WbWrite=1, WbReg=1, WbData=32'hABCD for 1 cycle → next cycle RegWrite_ctrl=1, WriteReg=1, WriteData=32'hABCD; following cycle RegWrite_ctrl=0.
- MDU pushes reg 2 = 32'h1234 and reg 3 = 32'h5678 back-to-back with WB idle → port shows reg 2 at push+2 and reg 3 at push+3. MduReady stays 1, because a pop frees a slot each cycle.
- Fill FIFO (regs 4, 5) while WbWrite=1 continuously → MduReady=0. After 4 WB-granted cycles, StallPipe=1 for one cycle and reg 4 is written. Busy1=1 while ReadReg1=5 until reg 5 pops.
- Queue MDU reg 6 = 32'h1111, then WB writes reg 6 = 32'h2222 in the next cycle → WriteData=32'h2222 committed. The killed entry issues RegWrite_ctrl=0, and Busy for reg 6 drops the cycle after the kill.
- WbReg=0 and MduReg=0 writes → RegWrite_ctrl never asserted; FIFO count unchanged by the MDU push.
- Assert rst_n=0 asynchronously with 2 entries queued, mid-cycle → outputs clear immediately. After release, no stale write appears and MduReady=1.
